// File: rtl/tanh_pkg.sv
// Shared types and constants for the tanh backward-pass unit.
package tanh_pkg;

    localparam int unsigned DW_DEFAULT    = 32;
    localparam int unsigned SCALE_DEFAULT = 100000000;

    // Saturation codes emitted by the forward tanh unit
    localparam logic [31:0] FWD_SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] FWD_SAT_NEG = 32'h8000_0000;

    typedef logic [63:0] wide_t;

    typedef enum logic [2:0] {
        StIdle,
        StSq,
        StDiv1,
        StMul,
        StDiv2,
        StOut
    } tanh_grad_state_t;

    // Magnitude of a signed forward activation, clamped to the fixed-point unit
    function automatic logic [31:0] abs_clamp(logic [31:0] v, logic [31:0] scale);
        logic [31:0] mag;
        if (v == FWD_SAT_POS || v == FWD_SAT_NEG) begin
            return scale;
        end
        mag = v[31] ? (~v + 32'd1) : v;
        return (mag > scale) ? scale : mag;
    endfunction

endpackage

// File: rtl/tanh_grad_if.sv
// Valid/ready request and response bundle for tanh_grad.
interface tanh_grad_if #(
    parameter int unsigned DW = 32
) ();
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] y;
    logic [DW-1:0] grad_y;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] grad_x;

    modport master (
        output in_valid, y, grad_y, out_ready,
        input  in_ready, out_valid, grad_x
    );

    modport slave (
        input  in_valid, y, grad_y, out_ready,
        output in_ready, out_valid, grad_x
    );
endinterface

// File: rtl/seq_udiv.sv
// 64-by-32 restoring divider, one quotient bit per cycle.
// The first bit is resolved on the start edge, so done pulses exactly 64 cycles after start.
module seq_udiv
    import tanh_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  wide_t       dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output wide_t       quotient
);
    logic [31:0] r_rem;
    wide_t       r_quot;
    logic [5:0]  r_cnt;
    logic        r_busy;
    logic        r_done;

    logic [31:0] w_rem_in;
    wide_t       w_quot_in;
    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_rem_nxt;
    wide_t       w_quot_nxt;

    // One restoring step; r_quot shifts dividend bits out as quotient bits shift in
    always_comb begin
        w_rem_in   = start ? 32'd0 : r_rem;
        w_quot_in  = start ? dividend : r_quot;
        w_rem_sh   = {w_rem_in, w_quot_in[63]};
        w_ge       = (w_rem_sh >= {1'b0, divisor});
        w_rem_nxt  = w_ge ? (w_rem_sh[31:0] - divisor) : w_rem_sh[31:0];
        w_quot_nxt = {w_quot_in[62:0], w_ge};
    end

    // Iteration counter, working registers and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rem  <= w_rem_nxt;
                r_quot <= w_quot_nxt;
                r_cnt  <= 6'd63;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem  <= w_rem_nxt;
                r_quot <= w_quot_nxt;
                r_cnt  <= r_cnt - 6'd1;
                if (r_cnt == 6'd1) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign quotient = r_quot;

endmodule

// File: rtl/tanh_grad.sv
// tanh backward pass: grad_x = grad_y * (1 - y^2) in SCALE fixed point.
// One shared sequential divider handles both /SCALE normalisations.
// Optional macro TANH_GRAD_FASTPATH_EN: trivial inputs (|y| saturated, y == 0,
// grad_y == 0) skip the arithmetic and reach OUT one edge after accept.
module tanh_grad
    import tanh_pkg::*;
#(
    parameter int unsigned DW    = DW_DEFAULT,
    parameter int unsigned SCALE = SCALE_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    tanh_grad_if.slave   bus
);
    localparam logic [31:0] SCALE_W = 32'(SCALE);

    tanh_grad_state_t r_state, w_state_nxt;
    logic [31:0]      r_y_abs,  w_y_abs_nxt;
    logic [31:0]      r_g_abs,  w_g_abs_nxt;
    logic             r_g_neg,  w_g_neg_nxt;
    logic [31:0]      r_d,      w_d_nxt;
    logic [DW-1:0]    r_grad_x, w_grad_x_nxt;
    logic             r_out_valid, w_out_valid_nxt;

    logic             w_div_start;
    wide_t            w_div_dividend;
    logic             w_div_busy;
    logic             w_div_done;
    wide_t            w_quot;
    logic [31:0]      w_q2;
    logic             w_unused;

`ifdef TANH_GRAD_FASTPATH_EN
    logic             w_fast_hit;
    logic [31:0]      w_g_signed;
`endif

    seq_udiv u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_div_start),
        .dividend (w_div_dividend),
        .divisor  (SCALE_W),
        .busy     (w_div_busy),
        .done     (w_div_done),
        .quotient (w_quot)
    );

    // Quotients never exceed 2^31, so only the low word matters
    assign w_unused = ^{w_div_busy, w_quot[63:32]};
    assign w_q2     = w_quot[31:0];

`ifdef TANH_GRAD_FASTPATH_EN
    assign w_g_signed = r_g_neg ? (~r_g_abs + 32'd1) : r_g_abs;
    assign w_fast_hit = (r_y_abs == SCALE_W) || (r_y_abs == 32'd0) || (r_g_abs == 32'd0);
`endif

    // Next-state, datapath updates and divider control
    always_comb begin
        w_state_nxt     = r_state;
        w_y_abs_nxt     = r_y_abs;
        w_g_abs_nxt     = r_g_abs;
        w_g_neg_nxt     = r_g_neg;
        w_d_nxt         = r_d;
        w_grad_x_nxt    = r_grad_x;
        w_out_valid_nxt = r_out_valid;
        w_div_start     = 1'b0;
        w_div_dividend  = '0;

        unique case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_y_abs_nxt = abs_clamp(bus.y, SCALE_W);
                    w_g_abs_nxt = bus.grad_y[DW-1] ? (~bus.grad_y + 32'd1) : bus.grad_y;
                    w_g_neg_nxt = bus.grad_y[DW-1];
                    w_state_nxt = StSq;
                end
            end
            StSq: begin
                w_div_start    = 1'b1;
                w_div_dividend = {32'd0, r_y_abs} * {32'd0, r_y_abs};
                w_state_nxt    = StDiv1;
`ifdef TANH_GRAD_FASTPATH_EN
                if (w_fast_hit) begin
                    w_div_start     = 1'b0;
                    // Saturated y gives a zero derivative; y == 0 passes grad_y through
                    w_grad_x_nxt    = (r_y_abs == 32'd0) ? w_g_signed : '0;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = StOut;
                end
`endif
            end
            StDiv1: begin
                if (w_div_done) begin
                    w_d_nxt     = SCALE_W - w_q2;
                    w_state_nxt = StMul;
                end
            end
            StMul: begin
                w_div_start    = 1'b1;
                w_div_dividend = {32'd0, r_g_abs} * {32'd0, r_d};
                w_state_nxt    = StDiv2;
            end
            StDiv2: begin
                if (w_div_done) begin
                    w_grad_x_nxt    = r_g_neg ? (~w_q2 + 32'd1) : w_q2;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = StOut;
                end
            end
            StOut: begin
                if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_y_abs     <= '0;
            r_g_abs     <= '0;
            r_g_neg     <= 1'b0;
            r_d         <= '0;
            r_grad_x    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_y_abs     <= w_y_abs_nxt;
            r_g_abs     <= w_g_abs_nxt;
            r_g_neg     <= w_g_neg_nxt;
            r_d         <= w_d_nxt;
            r_grad_x    <= w_grad_x_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = r_out_valid;
    assign bus.grad_x    = r_grad_x;

endmodule

// File: tb/tb_tanh_grad.sv
// Directed bench for tanh_grad: driver pushes expected results, a monitor pops on each transfer.
module tb_tanh_grad;

    logic clk;
    logic rst_n;

    tanh_grad_if #(.DW(32)) bus ();

    tanh_grad #(
        .DW    (32),
        .SCALE (100000000)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef TANH_GRAD_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, $signed(act), act,
                     $signed(exp), exp);
        end
    endtask

    function automatic bit fast_eligible(input logic [31:0] yv, input logic [31:0] gv);
        longint ya;
        ya = longint'($signed(yv));
        if (ya < 0) ya = -ya;
        return (ya >= 64'sd100000000) || (yv == 32'd0) || (gv == 32'd0);
    endfunction

    // Monitor: a transfer happens on the edge after valid && ready is seen here
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", bus.grad_x, 32'hDEAD_BEEF);
            end else begin
                mon_exp = exp_q.pop_front();
                check("grad_x", bus.grad_x, mon_exp);
            end
        end
    end

    // Issue one transaction; hold > 0 keeps out_ready low that many cycles after out_valid
    task automatic send(input logic [31:0] yv, input logic [31:0] gv, input logic [31:0] exp,
                        input int hold);
        int n;
        bit ready_low;
        int exp_lat;
        exp_lat = (FAST && fast_eligible(yv, gv)) ? 1 : 130;
        bus.out_ready = (hold == 0);
        n = 0;
        while (!bus.in_ready && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b1;
        bus.y        = yv;
        bus.grad_y   = gv;
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        // Inputs must be ignored after the accept edge
        bus.in_valid = 1'b0;
        bus.y        = ~yv;
        bus.grad_y   = gv ^ 32'h5A5A_5A5A;
        n = 0;
        ready_low = 1'b1;
        while (!bus.out_valid && n < 300) begin
            if (bus.in_ready) ready_low = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'(exp_lat));
        check("in_ready_low_busy", {31'd0, ready_low}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_grad_x", bus.grad_x, exp);
            check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        check("out_valid_after", {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.y         = '0;
        bus.grad_y    = '0;
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_grad_x", bus.grad_x, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(32'd0,          32'd100000000,  32'd100000000,          0);
        send(32'd50000000,   32'd100000000,  32'd75000000,           0);
        send(-32'sd50000000, 32'd100000000,  32'd75000000,           0);
        send(32'd50000000,   -32'sd40000000, -32'sd30000000,         0);
        send(32'd30000000,   32'd1,          32'd0,                  0);
        send(32'h7FFF_FFFF,  32'h8000_0000,  32'd0,                  0);
        send(32'd0,          32'h8000_0000,  32'h8000_0000,          0);
        send(32'd50000000,   -32'sd40000000, -32'sd30000000,         20);

        // Abort a transaction 40 edges after accept; the previous grad_x is non-zero
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.y         = 32'd50000000;
        bus.grad_y    = 32'd100000000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort_busy", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_grad_x", bus.grad_x, 32'd0);
        check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(32'd50000000,   32'd100000000,  32'd75000000,           0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
